imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, parametrised RISC-V immediate generator. Sits between fetch/decode and the
//  ALU/AGU operand mux. Decodes all base formats (I, S, B, U, J, shift-shamt) from a 32-bit
//  instruction into a sign- or zero-extended XLEN immediate.
//  Adds a valid/ready handshake, an output buffer and a saturating illegal-opcode counter.
// PARAMETERS
//  XLEN        64  immediate/output width; legal values 32 or 64
//  BUF_DEPTH   2   output buffer entries (power of 2, >=2); gives full-throughput backpressure
//  CNT_W       16  width of the illegal-opcode counter
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous, active-low reset
//  in_valid    in   1        instruction present
//  in_ready    out  1        block can accept (buffer not full)
//  in_instr    in   32       instruction word
//  out_valid   out  1        buffer head valid
//  out_ready   in   1        consumer accepts head
//  out_imm     out  XLEN     decoded immediate
//  out_fmt     out  3        format code (imm_gen_pkg::fmt_e)
//  out_illegal out  1        opcode has no immediate / unsupported
//  illegal_cnt out  CNT_W    saturating count of accepted illegal instructions
//  cnt_clr     in   1        synchronous clear of illegal_cnt
// BEHAVIOUR
//  Reset: in_ready=1 once rst_n deasserted; out_valid=0, out_imm=0, out_fmt=FMT_NONE,
//   out_illegal=0, illegal_cnt=0, buffer empty. rst_n assertion mid-stream drops all entries.
//  Accept when in_valid&&in_ready; pop when out_valid&&out_ready. Latency: accepted instr
//   appears at head on the next edge if buffer was empty. Push+pop same cycle when full is
//   allowed only if pop frees the slot; in_ready = !full (no combinational out_ready path).
//  Outputs stable while out_valid&&!out_ready. Order preserved; pointers wrap modulo BUF_DEPTH.
//  Decode (opcode = instr[6:0]), sign bit s = instr[31], sext to XLEN:
//   0000011 LOAD, 1100111 JALR, 1110011 SYSTEM, 0010011 OP-IMM -> FMT_I: sext(instr[31:20])
//   OP-IMM funct3 001/101 -> FMT_SH: zext shamt; instr[25:20] if XLEN=64, instr[24:20] if 32
//   0011011 OP-IMM-32 -> FMT_I (FMT_SH for funct3 001/101, shamt instr[24:20]); XLEN=32: illegal
//   0100011 STORE  -> FMT_S: sext({instr[31:25],instr[11:7]})
//   1100011 BRANCH -> FMT_B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
//   0110111 LUI, 0010111 AUIPC -> FMT_U: sext({instr[31:12],12'b0})
//   1101111 JAL    -> FMT_J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
//   any other      -> FMT_NONE, imm=0, out_illegal=1
//  illegal_cnt: +1 per accepted illegal instr; holds at all-ones; cnt_clr wins over increment.
//  Decode is combinational on in_instr; only the buffer and counter are registered.
// STRUCTURE
//  imm_gen_pkg: opcode localparams (OPC_LOAD...OPC_JAL), fmt_e enum (FMT_NONE=0, I, S, B, U,
//   J, SH), entry struct {imm, fmt, illegal}.
//  Sub-module imm_gen_buf: generic BUF_DEPTH-entry sync FIFO with valid/ready on both sides.
//  Top: decode function + imm_gen_buf instance + counter.
// TESTING
//  ld x1,-8(x2) (0xFF813083), out_ready=1 -> next cycle out_valid, imm=0xFFFFFFFFFFFFFFF8, FMT_I
//  sd x5,16(x2) (0x00513823) then beq -4 (0xFE000EE3) back-to-back -> imm 0x10 FMT_S, then
//   0xFFFFFFFFFFFFFFFC FMT_B, one per cycle, order kept
//  lui 0x12345 (0x123450B7); jal +2048 (0x0010006F); slli x1,x1,63 (0x03F09093)
//   -> 0x12345000 FMT_U, 0x800 FMT_J, 0x3F FMT_SH
//  out_ready=0 with 3 pushes -> in_ready=0 after 2; head stable; release -> drains in order
//  opcode 0x7F x(2^CNT_W+1), then cnt_clr with simultaneous illegal push -> saturates at
//   all-ones, out_illegal=1, imm=0; clear wins -> 0
//  rst_n low mid-stream with full buffer -> out_valid=0 async, counter=0; XLEN=32 build:
//   OP-IMM-32 -> illegal

Source files
------------

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared opcodes, format codes and buffer entry type for the immediate generator.
// The entry always carries a 64-bit immediate. Narrower builds truncate it at the output.
package imm_gen_pkg;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH} fmt_e;
  typedef struct packed {
    logic [63:0] imm;
    fmt_e        fmt;
    logic        illegal;
  } entry_t;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake bundle.
// The master side drives in_valid, in_instr and out_ready.
// The slave side (the generator) drives in_ready, out_valid, out_imm, out_fmt and out_illegal.
interface imm_gen_pipe_if #(parameter int XLEN = 64) ();
  import imm_gen_pkg::*;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  fmt_e            out_fmt;
  logic            out_illegal;
  modport master (output in_valid, in_instr, out_ready,
                  input  in_ready, out_valid, out_imm, out_fmt, out_illegal);
  modport slave  (input  in_valid, in_instr, out_ready,
                  output in_ready, out_valid, out_imm, out_fmt, out_illegal);
endinterface

// File: rtl/imm_gen_buf.sv
// imm_gen_buf: DEPTH-entry synchronous FIFO with valid/ready on both sides.
// Ports:
//   clk, rst_n                        clock and async active-low reset
//   in_valid_i, in_ready_o, in_data_i  write side
//   out_valid_o, out_ready_i, out_data_o  read side (head)
// in_ready_o depends only on state, so there is no combinational path from out_ready_i.
module imm_gen_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         push, pop;
  // Pointers carry one extra wrap bit. Full means the indices are equal and the wrap bits differ.
  assign out_valid_o = wr_q != rd_q;
  assign in_ready_o  = (wr_q ^ rd_q) != {1'b1, {AW{1'b0}}};
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign wr_d        = wr_q + (AW+1)'(push);
  assign rd_d        = rd_q + (AW+1)'(pop);
  assign out_data_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= in_data_i;
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator with an output buffer and an illegal-opcode counter.
// Ports:
//   clk, rst_n    clock and async active-low reset
//   bus (slave)   instruction in, immediate/format/illegal out, with valid/ready on both sides
//   cnt_clr       synchronous clear of illegal_cnt; takes priority over an increment
//   illegal_cnt   saturating count of accepted illegal instructions
module imm_gen_pipe import imm_gen_pkg::*; #(
  parameter int XLEN      = 64,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_gen_pipe_if.slave    bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);
  // Sign-extend to 64 bits and let the output truncate. The low XLEN bits match an XLEN-wide sign extension.
  function automatic entry_t decode(input logic [31:0] ins);
    entry_t e;
    logic   s, sh;
    s  = ins[31];
    sh = ins[14:12] == 3'b001 || ins[14:12] == 3'b101;
    e  = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};
    case (ins[6:0])
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        e.fmt = FMT_I;
        e.imm = {{52{s}}, ins[31:20]};
      end
      OPC_OP_IMM: begin
        e.fmt = sh ? FMT_SH : FMT_I;
        e.imm = !sh ? {{52{s}}, ins[31:20]} : XLEN == 64 ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
      end
      OPC_OP_IMM_32: begin
        e.illegal = XLEN == 32;
        e.fmt     = XLEN == 32 ? FMT_NONE : sh ? FMT_SH : FMT_I;
        e.imm     = XLEN == 32 ? '0 : sh ? {59'b0, ins[24:20]} : {{52{s}}, ins[31:20]};
      end
      OPC_STORE: begin
        e.fmt = FMT_S;
        e.imm = {{52{s}}, ins[31:25], ins[11:7]};
      end
      OPC_BRANCH: begin
        e.fmt = FMT_B;
        e.imm = {{51{s}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        e.fmt = FMT_U;
        e.imm = {{32{s}}, ins[31:12], 12'b0};
      end
      OPC_JAL: begin
        e.fmt = FMT_J;
        e.imm = {{43{s}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction
  entry_t           dec, head;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_ill;
  assign dec = decode(bus.in_instr);
  imm_gen_buf #(.W($bits(entry_t)), .DEPTH(BUF_DEPTH)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (dec),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (head)
  );
  // Buffer storage has no reset. Outputs are gated so an empty buffer presents the reset values.
  assign bus.out_imm     = bus.out_valid ? head.imm[XLEN-1:0] : '0;
  assign bus.out_fmt     = bus.out_valid ? head.fmt : FMT_NONE;
  assign bus.out_illegal = bus.out_valid && head.illegal;
  assign acc_ill         = bus.in_valid && bus.in_ready && dec.illegal;
  assign cnt_d           = cnt_clr ? '0 : (acc_ill && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  assign illegal_cnt     = cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table-driven vectors plus directed backpressure, saturation, reset and XLEN=32 sequences.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;
  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    fmt_e        fmt;
    logic        ill;
  } vec_t;
  logic       clk = 0, rst_n = 0, cnt_clr = 0, cnt_clr32 = 0;
  logic [3:0] cnt, cnt32;
  int         errors = 0, checks = 0;
  vec_t       v [16];
  imm_gen_pipe_if #(.XLEN(64)) bus ();
  imm_gen_pipe_if #(.XLEN(32)) bus32 ();
  imm_gen_pipe #(.XLEN(64), .BUF_DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clr(cnt_clr), .illegal_cnt(cnt));
  imm_gen_pipe #(.XLEN(32), .BUF_DEPTH(2), .CNT_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32), .cnt_clr(cnt_clr32), .illegal_cnt(cnt32));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic chk_head(input string nm, input logic [63:0] imm, input fmt_e f, input logic ill);
    chk({nm, ".valid"}, 64'(bus.out_valid), 64'd1);
    chk({nm, ".imm"}, bus.out_imm, imm);
    chk({nm, ".fmt"}, 64'(bus.out_fmt), 64'(f));
    chk({nm, ".ill"}, 64'(bus.out_illegal), 64'(ill));
  endtask
  initial begin
    v[0]  = '{32'hFF813083, 64'hFFFF_FFFF_FFFF_FFF8, FMT_I,    1'b0};
    v[1]  = '{32'h00513823, 64'h10,                  FMT_S,    1'b0};
    v[2]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B,    1'b0};
    v[3]  = '{32'h123450B7, 64'h12345000,            FMT_U,    1'b0};
    v[4]  = '{32'h0010006F, 64'h800,                 FMT_J,    1'b0};
    v[5]  = '{32'h03F09093, 64'h3F,                  FMT_SH,   1'b0};
    v[6]  = '{32'h0000007F, 64'h0,                   FMT_NONE, 1'b1};
    v[7]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I,    1'b0};
    v[8]  = '{32'h4030D093, 64'h3,                   FMT_SH,   1'b0};
    v[9]  = '{32'hFFE0809B, 64'hFFFF_FFFF_FFFF_FFFE, FMT_I,    1'b0};
    v[10] = '{32'h0050909B, 64'h5,                   FMT_SH,   1'b0};
    v[11] = '{32'h7FF08067, 64'h7FF,                 FMT_I,    1'b0};
    v[12] = '{32'h80000097, 64'hFFFF_FFFF_8000_0000, FMT_U,    1'b0};
    v[13] = '{32'h00000073, 64'h0,                   FMT_I,    1'b0};
    v[14] = '{32'hFE112FA3, 64'hFFFF_FFFF_FFFF_FFFF, FMT_S,    1'b0};
    v[15] = '{32'h002081B3, 64'h0,                   FMT_NONE, 1'b1};
    bus.in_valid = 0; bus.in_instr = 0; bus.out_ready = 0;
    bus32.in_valid = 0; bus32.in_instr = 0; bus32.out_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.imm", bus.out_imm, 64'd0);
    chk("rst.fmt", 64'(bus.out_fmt), 64'(FMT_NONE));
    chk("rst.ill", 64'(bus.out_illegal), 64'd0);
    chk("rst.cnt", 64'(cnt), 64'd0);
    // Back-to-back stream: vector k is driven at one negedge and must be at the head one cycle later.
    bus.out_ready = 1;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) chk_head($sformatf("vec%0d", k - 1), v[k-1].imm, v[k-1].fmt, v[k-1].ill);
      bus.in_valid = k < 16;
      if (k < 16) bus.in_instr = v[k].instr;
      @(negedge clk);
    end
    chk("stream.drained", 64'(bus.out_valid), 64'd0);
    chk("stream.cnt", 64'(cnt), 64'd2);
    // Backpressure: two fit, the third waits; head holds until released, then drains in order.
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_instr = 32'h123450B7;
    @(negedge clk);
    chk_head("bp.a", 64'h12345000, FMT_U, 1'b0);
    chk("bp.rdy1", 64'(bus.in_ready), 64'd1);
    bus.in_instr = 32'h0010006F;
    @(negedge clk);
    chk("bp.full", 64'(bus.in_ready), 64'd0);
    chk_head("bp.a_hold", 64'h12345000, FMT_U, 1'b0);
    bus.in_instr = 32'h03F09093;
    @(negedge clk);
    chk("bp.full2", 64'(bus.in_ready), 64'd0);
    chk_head("bp.a_stable", 64'h12345000, FMT_U, 1'b0);
    bus.out_ready = 1;
    @(negedge clk);
    chk_head("bp.b", 64'h800, FMT_J, 1'b0);
    chk("bp.rdy2", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 0;
    chk_head("bp.c", 64'h3F, FMT_SH, 1'b0);
    @(negedge clk);
    chk("bp.empty", 64'(bus.out_valid), 64'd0);
    // Saturation: clear, then 17 illegal accepts on a 4-bit counter; clear beats a same-cycle increment.
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    chk("sat.clr0", 64'(cnt), 64'd0);
    bus.in_valid = 1; bus.in_instr = 32'h0000007F;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 14) chk("sat.14", 64'(cnt), 64'd14);
    end
    chk("sat.max", 64'(cnt), 64'hF);
    chk_head("sat.head", 64'h0, FMT_NONE, 1'b1);
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0; bus.in_valid = 0;
    chk("sat.clr_wins", 64'(cnt), 64'd0);
    @(negedge clk);
    chk("sat.after", 64'(cnt), 64'd0);
    // XLEN=32 build: OP-IMM-32 is illegal, sign extension stops at bit 31, shamt is 5 bits.
    bus32.out_ready = 1;
    bus32.in_valid = 1; bus32.in_instr = 32'hFFE0809B;
    @(negedge clk);
    chk("x32.w.valid", 64'(bus32.out_valid), 64'd1);
    chk("x32.w.ill", 64'(bus32.out_illegal), 64'd1);
    chk("x32.w.imm", 64'(bus32.out_imm), 64'd0);
    chk("x32.w.fmt", 64'(bus32.out_fmt), 64'(FMT_NONE));
    bus32.in_instr = 32'hFF813083;
    @(negedge clk);
    chk("x32.ld.imm", 64'(bus32.out_imm), 64'hFFFF_FFF8);
    chk("x32.ld.fmt", 64'(bus32.out_fmt), 64'(FMT_I));
    bus32.in_instr = 32'h03F09093;
    @(negedge clk);
    bus32.in_valid = 0;
    chk("x32.sh.imm", 64'(bus32.out_imm), 64'h1F);
    chk("x32.sh.fmt", 64'(bus32.out_fmt), 64'(FMT_SH));
    @(negedge clk);
    chk("x32.cnt", 64'(cnt32), 64'd1);
    // Async reset with a full buffer and a nonzero counter.
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_instr = 32'h0000007F;
    @(negedge clk);
    bus.in_instr = 32'h123450B7;
    @(negedge clk);
    bus.in_valid = 0;
    chk("mid.full", 64'(bus.in_ready), 64'd0);
    chk("mid.cnt", 64'(cnt), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("mid.rst.valid", 64'(bus.out_valid), 64'd0);
    chk("mid.rst.ready", 64'(bus.in_ready), 64'd1);
    chk("mid.rst.cnt", 64'(cnt), 64'd0);
    chk("mid.rst.ill", 64'(bus.out_illegal), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("mid.post.valid", 64'(bus.out_valid), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
